// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending front-end.
package irq_pkg;

  localparam int NUM_IRQ = 4;
  localparam int ID_W    = $clog2(NUM_IRQ);

  // Per-line request type selected by irq_edge_mode
  localparam logic IRQ_MODE_LEVEL = 1'b0;
  localparam logic IRQ_MODE_EDGE  = 1'b1;

endpackage

// File: rtl/irq_sync.sv
// Single-bit reset-to-0 synchronizer, SYNC_STAGES flops deep.
module irq_sync
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: synchronizes request lines, detects edge/level
// requests, holds them pending until acknowledged, and tracks lost edges.
module irq_pending_ctrl #(
  parameter int NUM_IRQ     = irq_pkg::NUM_IRQ,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = irq_pkg::ID_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_raw,
  input  logic [NUM_IRQ-1:0] irq_edge_mode,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               ack_valid,
  input  logic [ID_W-1:0]    ack_id,
  input  logic [NUM_IRQ-1:0] ovf_clr,
  output logic [NUM_IRQ-1:0] interrupts,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] overflow
);

  import irq_pkg::*;

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] s_d;
  logic [NUM_IRQ-1:0] set_ev;
  logic [NUM_IRQ-1:0] ack_hit;
  logic [NUM_IRQ-1:0] ovf_ev;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] overflow_q;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (irq_raw[g]),
      .q    (s[g])
    );
  end

  // Delayed synchronized sample; tracks every cycle so a mode change never
  // fabricates an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d <= '0;
    end else begin
      s_d <= s;
    end
  end

  // Per-line set, acknowledge-hit and lost-edge detection
  always_comb begin
    set_ev  = '0;
    ack_hit = '0;
    ovf_ev  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      set_ev[i]  = (irq_edge_mode[i] == IRQ_MODE_EDGE) ? (s[i] & ~s_d[i]) : s[i];
      // Out-of-range ids match no line and are ignored
      ack_hit[i] = ack_valid && (int'(ack_id) == i);
      // An edge arriving on an already-pending line is lost, unless the same
      // edge acknowledges it (then the new edge simply replaces the old one)
      ovf_ev[i]  = (irq_edge_mode[i] == IRQ_MODE_EDGE) && set_ev[i] &&
                   pending_q[i] && !ack_hit[i];
    end
  end

  // Pending register: set beats acknowledge, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= set_ev | (pending_q & ~ack_hit);
    end
  end

  // Sticky overflow: a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= '0;
    end else begin
      overflow_q <= ovf_ev | (overflow_q & ~ovf_clr);
    end
  end

  assign interrupts = pending_q & irq_mask;
  assign pending    = pending_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: table of per-cycle vectors plus hand sequences
// for masking, reset and mode handling, checked through a scoreboard queue.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq_raw;
  logic [3:0] irq_edge_mode;
  logic [3:0] irq_mask;
  logic       ack_valid;
  logic [1:0] ack_id;
  logic [3:0] ovf_clr;
  logic [3:0] interrupts;
  logic [3:0] pending;
  logic [3:0] overflow;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] mode;
    logic [3:0] mask;
    logic       ackv;
    logic [1:0] id;
    logic [3:0] clr;
    logic [3:0] e_int;
    logic [3:0] e_pend;
    logic [3:0] e_ovf;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  vec_t sb[$];
  vec_t tbl[31];

  irq_pending_ctrl #(
    .NUM_IRQ    (4),
    .SYNC_STAGES(2),
    .ID_W       (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_raw      (irq_raw),
    .irq_edge_mode(irq_edge_mode),
    .irq_mask     (irq_mask),
    .ack_valid    (ack_valid),
    .ack_id       (ack_id),
    .ovf_clr      (ovf_clr),
    .interrupts   (interrupts),
    .pending      (pending),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] raw, input logic [3:0] mode,
                              input logic [3:0] mask, input logic ackv,
                              input logic [1:0] id, input logic [3:0] clr,
                              input logic [3:0] e_int, input logic [3:0] e_pend,
                              input logic [3:0] e_ovf);
    vec_t v;
    v.raw = raw; v.mode = mode; v.mask = mask; v.ackv = ackv; v.id = id;
    v.clr = clr; v.e_int = e_int; v.e_pend = e_pend; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%b want=%b", name, idx, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, record expectation, compare after
  // the next rising edge
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    irq_raw       = v.raw;
    irq_edge_mode = v.mode;
    irq_mask      = v.mask;
    ack_valid     = v.ackv;
    ack_id        = v.id;
    ovf_clr       = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty step=%0d got=0 want=1", step_no);
    end else begin
      e = sb.pop_front();
      check("interrupts", step_no, interrupts, e.e_int);
      check("pending",    step_no, pending,    e.e_pend);
      check("overflow",   step_no, overflow,   e.e_ovf);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Edge lines 0,2; level lines 1,3; all enabled
    //                raw     mode     mask   ack  id  clr     int     pend    ovf
    tbl[0]  = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    tbl[3]  = mk(4'b0100, 4'b0101, 4'hF, 1, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[4]  = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[5]  = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[6]  = mk(4'b0110, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[7]  = mk(4'b0110, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[8]  = mk(4'b0110, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    tbl[9]  = mk(4'b0110, 4'b0101, 4'hF, 1, 1, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    tbl[10] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    tbl[11] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    tbl[12] = mk(4'b0100, 4'b0101, 4'hF, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[13] = mk(4'b0101, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[14] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[15] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[16] = mk(4'b0101, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[17] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[18] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
    tbl[19] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    tbl[20] = mk(4'b0100, 4'b0101, 4'hF, 1, 3, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[21] = mk(4'b0101, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[22] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[23] = mk(4'b0100, 4'b0101, 4'hF, 1, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[24] = mk(4'b0100, 4'b0101, 4'hF, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[25] = mk(4'b0101, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[26] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[27] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[28] = mk(4'b0101, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[29] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[30] = mk(4'b0100, 4'b0101, 4'hF, 0, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001);

    rst_n = 1'b0;
    irq_raw = '0; irq_edge_mode = '0; irq_mask = '0;
    ack_valid = 1'b0; ack_id = '0; ovf_clr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_interrupts", 0, interrupts, 4'b0000);
    check("rst_pending",    0, pending,    4'b0000);
    check("rst_overflow",   0, overflow,   4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 31; i++) step(tbl[i]);

    // Clear line 0, bring up level lines 3 and 1
    step(mk(4'b1010, 4'b0101, 4'hF, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001));
    step(mk(4'b1010, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001));
    step(mk(4'b1010, 4'b0101, 4'hF, 0, 0, 4'b0000, 4'b1010, 4'b1010, 4'b0001));
    step(mk(4'b1010, 4'b0101, 4'hF, 0, 0, 4'b0001, 4'b1010, 4'b1010, 4'b0000));

    // Masking acts within the same cycle and leaves pending alone
    @(negedge clk);
    irq_mask = 4'b0111;
    #1;
    check("mask_interrupts", 100, interrupts, 4'b0010);
    check("mask_pending",    100, pending,    4'b1010);
    step(mk(4'b1010, 4'b0101, 4'b0111, 0, 0, 4'b0000, 4'b0010, 4'b1010, 4'b0000));
    @(negedge clk);
    irq_mask = 4'hF;
    #1;
    check("unmask_interrupts", 101, interrupts, 4'b1010);

    // Fill all lines as level requests
    step(mk(4'b1111, 4'b0000, 4'hF, 0, 0, 4'b0000, 4'b1010, 4'b1010, 4'b0000));
    step(mk(4'b1111, 4'b0000, 4'hF, 0, 0, 4'b0000, 4'b1010, 4'b1010, 4'b0000));
    step(mk(4'b1111, 4'b0000, 4'hF, 0, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000));

    // Asynchronous reset between edges, edge-type lines held high through it
    @(negedge clk);
    irq_edge_mode = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("arst_interrupts", 102, interrupts, 4'b0000);
    check("arst_pending",    102, pending,    4'b0000);
    check("arst_overflow",   102, overflow,   4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_e0_pending", 103, pending, 4'b0000);
    step(mk(4'b1111, 4'b1111, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    step(mk(4'b1111, 4'b1111, 4'hF, 0, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000));
    step(mk(4'b1111, 4'b1111, 4'hF, 0, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000));

    // Acked edge line held high stays clear
    step(mk(4'b1111, 4'b1111, 4'hF, 1, 0, 4'b0000, 4'b1110, 4'b1110, 4'b0000));
    step(mk(4'b1111, 4'b1111, 4'hF, 0, 0, 4'b0000, 4'b1110, 4'b1110, 4'b0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
